// File: rtl/prng_stream_buf_if.sv
// Stream bundle between a combined-PRNG sampler and its consumer:
// the sample side (prng_in/prng_en) and the buffered output handshake.
interface prng_stream_buf_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] prng_in;
  logic              prng_en;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output prng_in,
    output prng_en,
    output out_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  prng_in,
    input  prng_en,
    input  out_ready,
    output out_data,
    output out_valid
  );
endinterface

// File: rtl/prng_stream_buf.sv
// Buffers combined-PRNG samples in a small FIFO, counts overflow drops and
// flags a generator that repeats the same word STUCK_LIMIT times in a row.
module prng_stream_buf #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int STUCK_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  prng_stream_buf_if.slave         bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               drop_cnt,
  output logic                     stuck,
  input  logic                     clr_stuck
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = $clog2(STUCK_LIMIT);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [RW-1:0] RUN_MAX  = RW'(STUCK_LIMIT - 1);
  localparam logic [RW-1:0] RUN_SET  = RW'(STUCK_LIMIT - 2);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic              have_last_q, have_last_d;
  logic [RW-1:0]     run_q, run_d;
  logic              stuck_q, stuck_d;

  logic pop_s;
  logic can_take_s;
  logic push_s;
  logic drop_s;
  logic same_s;
  logic set_s;

  // Handshake decode: a full FIFO still accepts a word when a pop frees a slot
  always_comb begin
    pop_s      = out_valid_q & bus.out_ready;
    can_take_s = (level_q != FULL_LVL) | pop_s;
    push_s     = bus.prng_en & ~stuck_q & can_take_s;
    drop_s     = bus.prng_en & ~stuck_q & ~can_take_s;
  end

  // FIFO storage, pointers, occupancy and the registered head word
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = bus.prng_in;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    out_valid_d = (level_d != {LW{1'b0}});
    // Head is taken from the post-edge memory image, so a word pushed into an
    // empty FIFO shows up exactly one cycle after its push edge.
    out_data_d  = mem_d[rd_ptr_d];
  end

  // Saturating overflow counter; stuck refusals are not drops
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_s && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Repeat-run tracking and the sticky stuck flag
  always_comb begin
    last_d      = last_q;
    have_last_d = have_last_q;
    run_d       = run_q;
    same_s      = have_last_q & (bus.prng_in == last_q);
    set_s       = bus.prng_en & same_s & (run_q == RUN_SET);
    if (bus.prng_en) begin
      last_d      = bus.prng_in;
      have_last_d = 1'b1;
      if (same_s) begin
        run_d = (run_q == RUN_MAX) ? run_q : (run_q + RW'(1));
      end else begin
        run_d = {RW{1'b0}};
      end
    end else begin
      last_d      = last_q;
      have_last_d = have_last_q;
      run_d       = run_q;
    end
    if (clr_stuck) begin
      stuck_d     = set_s;
      run_d       = {RW{1'b0}};
      have_last_d = 1'b0;
    end else begin
      stuck_d = stuck_q | set_s;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      level_q     <= {LW{1'b0}};
      out_data_q  <= {DATA_W{1'b0}};
      out_valid_q <= 1'b0;
      drop_cnt_q  <= 8'd0;
      last_q      <= {DATA_W{1'b0}};
      have_last_q <= 1'b0;
      run_q       <= {RW{1'b0}};
      stuck_q     <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      drop_cnt_q  <= drop_cnt_d;
      last_q      <= last_d;
      have_last_q <= have_last_d;
      run_q       <= run_d;
      stuck_q     <= stuck_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign level         = level_q;
  assign drop_cnt      = drop_cnt_q;
  assign stuck         = stuck_q;

endmodule

// File: doc/prng_stream_buf.md
PRNG_STREAM_BUF -- requirements
Module: prng_stream_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning width of the combined PRNG word consumed (the LOWER-layer width).
REQ-002 SHALL have parameter DEPTH, default 4, meaning FIFO entries; power of two, minimum 2.
REQ-003 SHALL have parameter STUCK_LIMIT, default 4, meaning the number of identical consecutive samples that flags a stuck generator; minimum 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port prng_in, input, DATA_W bits: the combined PRNG word (UP-LFSR low bits XOR DOWN-LFSR).
REQ-007 SHALL have port prng_en, input, 1 bit: sample strobe; prng_in is sampled on every edge where this is high.
REQ-008 SHALL have port out_data, output, DATA_W bits: FIFO head word.
REQ-009 SHALL have port out_valid, output, 1 bit: high when the FIFO is non-empty.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts out_data.
REQ-011 SHALL have port level, output, clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-012 SHALL have port drop_cnt, output, 8 bits: count of samples lost to overflow, saturating.
REQ-013 SHALL have port stuck, output, 1 bit: sticky stuck-generator flag.
REQ-014 SHALL have port clr_stuck, input, 1 bit: clears stuck and the run counter.

Function
REQ-015 SHALL complete a pop on an edge where out_valid=1 and out_ready=1; out_ready is ignored when out_valid=0.
REQ-016 SHALL push prng_in on an edge where prng_en=1, stuck=0 (pre-edge value), and either level<DEPTH or a pop completes on the same edge.
REQ-017 SHALL increment drop_cnt (saturating at 255) when a push is refused only because the FIFO is full with no simultaneous pop; refusal due to stuck SHALL NOT count as a drop.
REQ-018 SHALL update level by +1 for push only, -1 for pop only, and 0 for push and pop together or for neither.
REQ-019 SHALL assert out_valid and present the pushed word on out_data in the cycle after the push edge (1-cycle latency); empty-FIFO bypass is not permitted.
REQ-020 SHALL deliver words strictly in push order; read and write pointers wrap modulo DEPTH.
REQ-021 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-022 SHALL hold an internal last-sample register and a have_last bit; on every prng_en edge, last<=prng_in and have_last<=1, independent of any push or drop.
REQ-023 SHALL handle the run counter on each prng_en edge as follows: if have_last=1 and prng_in==last, run<=run+1, saturating at STUCK_LIMIT-1; otherwise run<=0.
REQ-024 SHALL set stuck on the edge where run is STUCK_LIMIT-2 and a further equal sample arrives, that is, STUCK_LIMIT identical consecutive samples.
REQ-025 SHALL clear stuck and run, and clear have_last, on an edge with clr_stuck=1; if a set condition occurs on the same edge, set wins for stuck, and the run counter still clears.
REQ-026 SHALL keep FIFO pops active while stuck=1, so the consumer can drain buffered data.
REQ-027 SHALL leave prng_en=0 edges with no effect on the FIFO-input side, last, or run.

Reset
REQ-028 SHALL, on an edge with rst_n=0, clear level, the pointers, out_valid, run, have_last, stuck, and drop_cnt to 0, and drive out_data to 0.
REQ-029 SHALL give rst_n=0 priority over every other input, discarding any buffered data mid-operation.
REQ-030 SHALL make all outputs valid and at their reset values from the first edge after reset is asserted.

Verification
REQ-031 Scenario: after reset, prng_en pulses with 0x11, 0x22, 0x33 and out_ready=0 -> level=3, out_data=0x11; then out_ready=1 for 3 cycles -> 0x11, 0x22, 0x33 in order, then out_valid=0.
REQ-032 Scenario: out_ready=0 and 6 distinct samples with DEPTH=4 -> level=4, drop_cnt=2, and the first 4 words are retained.
REQ-033 Scenario: full FIFO, push and pop on the same edge -> level stays 4, drop_cnt unchanged, and the newest word is appended at the tail.
REQ-034 Scenario: samples 0x5A x4 -> stuck=1 after the 4th edge; a 5th sample of 0xA5 is not pushed and drop_cnt is unchanged; clr_stuck=1 -> stuck=0 and pushes resume.
REQ-035 Scenario: 300 overflow drops -> drop_cnt=255, with no wrap-around.
REQ-036 Scenario: rst_n=0 for one edge with level=3 and stuck=1 -> level=0, out_valid=0, stuck=0, and drop_cnt=0 on the next cycle.
